// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field slices, opcode/aluop
// constants and the mult/div sequencer state encoding.
package proc_pkg;

    // Instruction field bit positions
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    // Opcodes (addi follows the usual 00101 encoding of this ISA)
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    // R-type aluop values that use the multicycle unit
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_START = 2'd1,
        MD_WAIT  = 2'd2,
        MD_DONE  = 2'd3
    } md_state_e;

    function automatic logic [4:0] opcodeOf(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [4:0] rdOf(input logic [31:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [4:0] rsOf(input logic [31:0] ir);
        return ir[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rtOf(input logic [31:0] ir);
        return ir[RT_HI:RT_LO];
    endfunction

    function automatic logic [4:0] aluopOf(input logic [31:0] ir);
        return ir[ALUOP_HI:ALUOP_LO];
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div start/ready handshake sequencer. Issues a one-cycle start pulse,
// waits (unbounded) for the result, then presents a one-cycle write enable
// with the exception flag captured on the ready cycle.
module md_sequencer
    import proc_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic startReq_i,
    input  logic startIsDiv_i,
    input  logic mdResultRdy_i,
    input  logic mdException_i,
    output logic busy_o,
    output logic ctrlMult_o,
    output logic ctrlDiv_o,
    output logic mdWriteEn_o,
    output logic mdExcep_o
);

    md_state_e mdState_q;
    md_state_e mdState_d;
    logic      isDiv_q;
    logic      excep_q;
    logic      resultTaken;

    // Ready only matters while an operation is outstanding
    assign resultTaken = ((mdState_q == MD_START) || (mdState_q == MD_WAIT)) && mdResultRdy_i;

    // Next-state logic; DONE always returns through IDLE so a following op is decoded fresh
    always_comb begin
        mdState_d = mdState_q;
        case (mdState_q)
            MD_IDLE:  if (startReq_i) mdState_d = MD_START;
            MD_START: mdState_d = mdResultRdy_i ? MD_DONE : MD_WAIT;
            MD_WAIT:  if (mdResultRdy_i) mdState_d = MD_DONE;
            MD_DONE:  mdState_d = MD_IDLE;
            default:  mdState_d = MD_IDLE;
        endcase
    end

    // State, latched op type and exception capture; reset discards any pending result
    always_ff @(posedge clock) begin
        if (reset) begin
            mdState_q <= MD_IDLE;
            isDiv_q   <= 1'b0;
            excep_q   <= 1'b0;
        end else begin
            mdState_q <= mdState_d;
            if ((mdState_q == MD_IDLE) && startReq_i)
                isDiv_q <= startIsDiv_i;
            if (resultTaken)
                excep_q <= mdException_i;
        end
    end

    assign busy_o      = (mdState_q == MD_START) || (mdState_q == MD_WAIT);
    assign ctrlMult_o  = (mdState_q == MD_START) && !isDiv_q;
    assign ctrlDiv_o   = (mdState_q == MD_START) &&  isDiv_q;
    assign mdWriteEn_o = (mdState_q == MD_DONE);
    assign mdExcep_o   = (mdState_q == MD_DONE) && excep_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: load-use detection between F/D and D/X,
// branch flush priority, mult/div stall sequencing and a saturating count
// of fetch-stall cycles.
module stall_ctrl
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      irFD,
    input  logic [31:0]      irDX,
    input  logic             takenDX,
    input  logic             mdResultRdy,
    input  logic             mdException,
    output logic             stallF,
    output logic             stallD,
    output logic             bubbleDX,
    output logic             bubbleXM,
    output logic             flushFD,
    output logic             ctrlMult,
    output logic             ctrlDiv,
    output logic             mdWriteEn,
    output logic             mdExcep,
    output logic [CNT_W-1:0] stallCount
);

    logic [4:0]       opFD;
    logic [4:0]       opDX;
    logic [4:0]       rdDX;
    logic             readsRs;
    logic             readsRt;
    logic             readsRd;
    logic             srcMatch;
    logic             loadUse;
    logic             isMulDX;
    logic             isDivDX;
    logic             mdBusy;
    logic             startReq;
    logic [CNT_W-1:0] stallCount_q;
    logic             unusedIrBits;

    assign opFD = opcodeOf(irFD);
    assign opDX = opcodeOf(irDX);
    assign rdDX = rdOf(irDX);

    // Which register fields the F/D instruction actually reads
    always_comb begin
        readsRs = 1'b0;
        readsRt = 1'b0;
        readsRd = 1'b0;
        case (opFD)
            OP_RTYPE: begin
                readsRs = 1'b1;
                readsRt = 1'b1;
            end
            OP_ADDI, OP_LW: readsRs = 1'b1;
            OP_SW, OP_BNE, OP_BLT: begin
                readsRd = 1'b1;
                readsRs = 1'b1;
            end
            OP_JR:   readsRd = 1'b1;
            default: ;
        endcase
    end

    assign srcMatch = (readsRs && (rsOf(irFD) == rdDX)) ||
                      (readsRt && (rtOf(irFD) == rdDX)) ||
                      (readsRd && (rdOf(irFD) == rdDX));

    // Masked while mult/div is busy since F/D is frozen then anyway
    assign loadUse = (opDX == OP_LW) && (rdDX != 5'd0) && srcMatch && !mdBusy;

    assign isMulDX = (opDX == OP_RTYPE) && (aluopOf(irDX) == ALU_MUL);
    assign isDivDX = (opDX == OP_RTYPE) && (aluopOf(irDX) == ALU_DIV);

    // Busy mult/div dominates; otherwise a taken branch beats load-use
    assign flushFD  = takenDX && !mdBusy;
    assign bubbleDX = !mdBusy && (takenDX || loadUse);
    assign stallF   = mdBusy || (loadUse && !takenDX);
    assign stallD   = mdBusy;
    assign bubbleXM = mdBusy;

    assign startReq = (isMulDX || isDivDX) && !bubbleDX && !takenDX;

    md_sequencer u_md_sequencer (
        .clock         (clock),
        .reset         (reset),
        .startReq_i    (startReq),
        .startIsDiv_i  (isDivDX),
        .mdResultRdy_i (mdResultRdy),
        .mdException_i (mdException),
        .busy_o        (mdBusy),
        .ctrlMult_o    (ctrlMult),
        .ctrlDiv_o     (ctrlDiv),
        .mdWriteEn_o   (mdWriteEn),
        .mdExcep_o     (mdExcep)
    );

    // Saturating count of cycles in which fetch is held
    always_ff @(posedge clock) begin
        if (reset)
            stallCount_q <= '0;
        else if (stallF && (stallCount_q != {CNT_W{1'b1}}))
            stallCount_q <= stallCount_q + 1'b1;
    end

    assign stallCount = stallCount_q;

    // Fields the controller never looks at
    assign unusedIrBits = ^{irFD[11:0], irDX[16:7], irDX[1:0]};

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: load-use, r0 exemption,
// mul/div sequencing, flush priority and reset during a pending op.
module tb_stall_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] irFD;
    logic [31:0] irDX;
    logic        takenDX;
    logic        mdResultRdy;
    logic        mdException;
    logic        stallF;
    logic        stallD;
    logic        bubbleDX;
    logic        bubbleXM;
    logic        flushFD;
    logic        ctrlMult;
    logic        ctrlDiv;
    logic        mdWriteEn;
    logic        mdExcep;
    logic [15:0] stallCount;

    int checks = 0;
    int errors = 0;
    int pulses;

    stall_ctrl #(.CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .irFD        (irFD),
        .irDX        (irDX),
        .takenDX     (takenDX),
        .mdResultRdy (mdResultRdy),
        .mdException (mdException),
        .stallF      (stallF),
        .stallD      (stallD),
        .bubbleDX    (bubbleDX),
        .bubbleXM    (bubbleXM),
        .flushFD     (flushFD),
        .ctrlMult    (ctrlMult),
        .ctrlDiv     (ctrlDiv),
        .mdWriteEn   (mdWriteEn),
        .mdExcep     (mdExcep),
        .stallCount  (stallCount)
    );

    // Free-running 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mkR(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] mkI(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx, input logic taken,
                                 input logic rdy, input logic exc);
        irFD        = fd;
        irDX        = dx;
        takenDX     = taken;
        mdResultRdy = rdy;
        mdException = exc;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkAllQuiet(input string pfx);
        checkOutput({pfx, "_stallF"},     stallF,     0);
        checkOutput({pfx, "_stallD"},     stallD,     0);
        checkOutput({pfx, "_bubbleDX"},   bubbleDX,   0);
        checkOutput({pfx, "_bubbleXM"},   bubbleXM,   0);
        checkOutput({pfx, "_flushFD"},    flushFD,    0);
        checkOutput({pfx, "_ctrlMult"},   ctrlMult,   0);
        checkOutput({pfx, "_ctrlDiv"},    ctrlDiv,    0);
        checkOutput({pfx, "_mdWriteEn"},  mdWriteEn,  0);
        checkOutput({pfx, "_mdExcep"},    mdExcep,    0);
        checkOutput({pfx, "_stallCount"}, stallCount, 0);
    endtask

    initial begin
        logic [31:0] lwR5;
        logic [31:0] addR5;
        logic [31:0] mulOp;
        logic [31:0] divOp;
        lwR5  = mkI(5'b01000, 5'd5, 5'd1);
        addR5 = mkR(5'd3, 5'd5, 5'd2, 5'd0);
        mulOp = mkR(5'd4, 5'd1, 5'd2, 5'b00110);
        divOp = mkR(5'd4, 5'd1, 5'd2, 5'b00111);

        // Reset state
        doReset();
        #1;
        checkAllQuiet("reset");

        // Load-use on rs, then other source fields and non-readers
        applyStimulus(addR5, lwR5, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_rs_stallF",   stallF,   1);
        checkOutput("lu_rs_bubbleDX", bubbleDX, 1);
        checkOutput("lu_rs_stallD",   stallD,   0);
        checkOutput("lu_rs_flushFD",  flushFD,  0);
        irFD = mkR(5'd3, 5'd2, 5'd5, 5'd0);
        #1 checkOutput("lu_rt_stallF", stallF, 1);
        irFD = mkI(5'b00111, 5'd5, 5'd1);
        #1 checkOutput("lu_sw_rd_stallF", stallF, 1);
        irFD = mkI(5'b00100, 5'd5, 5'd0);
        #1 checkOutput("lu_jr_stallF", stallF, 1);
        irFD = mkI(5'b00101, 5'd7, 5'd5);
        #1 checkOutput("lu_addi_rs_stallF", stallF, 1);
        irFD = mkI(5'b00101, 5'd5, 5'd1);
        #1 checkOutput("lu_addi_rd_stallF", stallF, 0);
        irFD = mkI(5'b00001, 5'd5, 5'd5);
        #1 checkOutput("lu_jump_stallF", stallF, 0);
        irFD = addR5;
        step();
        checkOutput("lu_count1", stallCount, 1);
        irDX = NOP;
        #1;
        checkOutput("lu_clear_stallF",   stallF,   0);
        checkOutput("lu_clear_bubbleDX", bubbleDX, 0);
        step();
        checkOutput("lu_count_hold", stallCount, 1);

        // lw to r0 never stalls
        applyStimulus(mkR(5'd3, 5'd0, 5'd0, 5'd0), mkI(5'b01000, 5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("r0_stallF",   stallF,   0);
        checkOutput("r0_bubbleDX", bubbleDX, 0);

        // mul with four WAIT cycles, ready in the last one
        doReset();
        applyStimulus(mkR(5'd6, 5'd7, 5'd8, 5'd0), mulOp, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mul_idle_ctrlMult", ctrlMult, 0);
        checkOutput("mul_idle_stallF",   stallF,   0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 4) mdResultRdy = 1'b1;
            #1;
            pulses += int'(ctrlMult);
            checkOutput($sformatf("mul_stallF_c%0d", c),   stallF,   1);
            checkOutput($sformatf("mul_stallD_c%0d", c),   stallD,   1);
            checkOutput($sformatf("mul_bubbleXM_c%0d", c), bubbleXM, 1);
            checkOutput($sformatf("mul_bubbleDX_c%0d", c), bubbleDX, 0);
            checkOutput($sformatf("mul_ctrlDiv_c%0d", c),  ctrlDiv,  0);
        end
        step();
        mdResultRdy = 1'b0;
        irDX = NOP;
        #1;
        pulses += int'(ctrlMult);
        checkOutput("mul_done_wen",    mdWriteEn,  1);
        checkOutput("mul_done_stallF", stallF,     0);
        checkOutput("mul_done_stallD", stallD,     0);
        checkOutput("mul_done_bxm",    bubbleXM,   0);
        checkOutput("mul_done_excep",  mdExcep,    0);
        checkOutput("mul_count5",      stallCount, 5);
        step();
        pulses += int'(ctrlMult);
        checkOutput("mul_after_wen",   mdWriteEn,  0);
        checkOutput("mul_after_count", stallCount, 5);
        checkOutput("mul_pulses",      pulses,     1);

        // div with ready during START and an exception
        doReset();
        applyStimulus(NOP, divOp, 1'b0, 1'b0, 1'b0);
        #1;
        step();
        mdResultRdy = 1'b1;
        mdException = 1'b1;
        #1;
        checkOutput("div_start_ctrlDiv",  ctrlDiv,  1);
        checkOutput("div_start_ctrlMult", ctrlMult, 0);
        checkOutput("div_start_stallF",   stallF,   1);
        step();
        mdResultRdy = 1'b0;
        mdException = 1'b0;
        irDX = NOP;
        #1;
        checkOutput("div_done_wen",     mdWriteEn,  1);
        checkOutput("div_done_excep",   mdExcep,    1);
        checkOutput("div_done_ctrlDiv", ctrlDiv,    0);
        checkOutput("div_done_stallF",  stallF,     0);
        checkOutput("div_count1",       stallCount, 1);
        step();
        checkOutput("div_after_wen",   mdWriteEn, 0);
        checkOutput("div_after_excep", mdExcep,   0);

        // Flush beats load-use, and a taken branch blocks a mul start
        doReset();
        applyStimulus(addR5, lwR5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("flush_flushFD",  flushFD,  1);
        checkOutput("flush_bubbleDX", bubbleDX, 1);
        checkOutput("flush_stallF",   stallF,   0);
        step();
        checkOutput("flush_count0", stallCount, 0);
        applyStimulus(NOP, mulOp, 1'b1, 1'b0, 1'b0);
        #1;
        step();
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_mul_ctrlMult", ctrlMult, 0);
        checkOutput("flush_mul_stallF",   stallF,   0);

        // Reset while waiting; a late ready must be ignored
        doReset();
        applyStimulus(NOP, mulOp, 1'b0, 1'b0, 1'b0);
        #1;
        step();
        step();
        checkOutput("rst_wait_stallF", stallF, 1);
        reset = 1'b1;
        applyStimulus(NOP, NOP, 1'b0, 1'b0, 1'b0);
        step();
        checkAllQuiet("rst_mid");
        reset = 1'b0;
        mdResultRdy = 1'b1;
        step();
        checkOutput("rst_late_wen",    mdWriteEn, 0);
        checkOutput("rst_late_stallF", stallF,    0);
        step();
        checkOutput("rst_late_wen2", mdWriteEn, 0);
        mdResultRdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall and flush controller for the 5-stage processor. It is the counterpart to forwarding: it handles the hazards that bypassing cannot resolve. It detects load-use hazards between F/D and D/X and sequences the multicycle mult/div unit through a start/ready handshake. It also flushes wrong-path instructions on a taken branch or jump resolved in X. Its outputs drive the PC and latch enables, the bubble muxes in front of D/X and X/M, and the mult/div control inputs.

## Interface
- CNT_W, 16, width of the saturating stall-cycle counter
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- irFD  in  32  instruction in F/D latch
- irDX  in  32  instruction in D/X latch
- takenDX  in  1  branch/jump in X is taken (redirect this cycle)
- mdResultRdy  in  1  mult/div result valid (level, sampled each cycle)
- mdException  in  1  mult/div exception, valid with mdResultRdy
- stallF  out  1  hold PC and F/D latch
- stallD  out  1  hold D/X latch
- bubbleDX  out  1  load nop into D/X next edge
- bubbleXM  out  1  load nop into X/M next edge
- flushFD  out  1  load nop into F/D next edge
- ctrlMult, ctrlDiv  out  1 each  one-cycle start pulses to mult/div
- mdWriteEn  out  1  mult/div result enters X/M this cycle
- mdExcep  out  1  registered exception flag, valid while mdWriteEn
- stallCount  out  CNT_W  cycles with stallF high, saturating

## Operation
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]. Opcode 00000 = R-type; lw = 01000. mul is R-type with aluop 00110; div is R-type with aluop 00111.
- F/D source registers:
  - R-type reads rs and rt.
  - addi, lw read rs.
  - sw (00111), bne (00010), blt (00110) read rd and rs.
  - jr (00100) reads rd.
  - All other opcodes read nothing.
- Load-use: irDX is lw, its rd is nonzero, and its rd equals any F/D source. Result: stallF=1 and bubbleDX=1, combinational, one cycle only. The lw advances to X/M, which clears the condition.
- Flush: takenDX forces flushFD=1 and bubbleDX=1. It overrides load-use, so stallF=0 that cycle.
- Mult/div FSM states MD_IDLE, MD_START, MD_WAIT, MD_DONE:
  - MD_IDLE → MD_START: irDX is mul/div and neither bubbleDX nor takenDX is asserted. Latch the op type.
  - MD_START: exactly one of ctrlMult/ctrlDiv = 1. → MD_DONE if mdResultRdy, else → MD_WAIT.
  - MD_WAIT: → MD_DONE on mdResultRdy. Otherwise stay; there is no timeout.
  - MD_DONE: mdWriteEn=1, mdExcep = mdException registered on the ready cycle. Stalls released. → MD_IDLE.
- In MD_START and MD_WAIT, all of these hold: stallF=1, stallD=1, bubbleXM=1, bubbleDX=0.
- Load-use detection is masked while in MD_START or MD_WAIT; the F/D instruction is frozen anyway.
- mdResultRdy is ignored in MD_IDLE and MD_DONE.
- A back-to-back mul/div leaves MD_DONE through MD_IDLE. Minimum 1 idle cycle, so the new D/X instruction is evaluated fresh.
- stallCount increments each cycle stallF=1 and saturates at all-ones.

## Timing
- Reset: FSM → MD_IDLE, stallCount=0, mdExcep=0. All other outputs 0, given irDX and irFD hold nops during reset.
- Hazard and flush outputs are combinational from current inputs plus FSM state. Start, write and exception outputs are decoded from registered state.
- Start-pulse latency: ctrlMult/ctrlDiv rise one cycle after the mul/div is visible in irDX.
- Minimum mult/div occupancy of D/X is 3 cycles (IDLE-detect, START with ready, DONE).
- Reset mid-operation: next edge → MD_IDLE, pulses and stalls drop, any pending result is discarded.

## Structure
- Shared package `proc_pkg`:
  - opcode and aluop constants (lw, sw, bne, blt, jr, R-type, mul, div)
  - field-slice localparams
  - MD state enum
- Sub-module `md_sequencer` holds the mult/div FSM and exception register. The top level holds source decode, load-use compare, flush priority and the counter.

## Test plan
- lw r5 in D/X, add r3,r5,r2 in F/D → stallF=1 and bubbleDX=1 for exactly 1 cycle. stallCount=1.
- lw r0 in D/X, any reader of r0 in F/D → no stall.
- mul in D/X, mdResultRdy after 4 WAIT cycles:
  - ctrlMult pulses once.
  - stallF/stallD/bubbleXM=1 for 5 cycles, then mdWriteEn=1 for 1 cycle.
  - stallCount=5.
- div with mdResultRdy=1 during START → MD_DONE next cycle. mdException=1 gives mdExcep=1 in DONE.
- takenDX=1 with simultaneous load-use → flushFD=1, bubbleDX=1, stallF=0.
- reset asserted in MD_WAIT → next cycle all outputs 0, state MD_IDLE. A late mdResultRdy does not produce mdWriteEn.
